// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg : shared funct3 codes, FSM states and trap causes for the
// MEM-stage load/store unit.                                  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [63:0] MCAUSE_LOAD_MISALIGN  = 64'd4;
    localparam logic [63:0] MCAUSE_STORE_MISALIGN = 64'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Access size lives in funct3[1:0]; the sign bit does not affect alignment.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] offset);
        logic result;
        case (funct3[1:0])
            2'b00:   result = 1'b0;
            2'b01:   result = offset[0];
            2'b10:   result = |offset[1:0];
            default: result = |offset;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align : byte-lane store alignment, write mask and load extension.
//                                                             Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_align
    import mem_access_pkg::*;
#(
    parameter int BUS_W = 64
) (
    input  logic [2:0]         funct3,
    input  logic [2:0]         offset,
    input  logic [BUS_W-1:0]   sdata,
    input  logic [BUS_W-1:0]   rdata,
    output logic [BUS_W/8-1:0] wmask,
    output logic [BUS_W-1:0]   wdata,
    output logic [BUS_W-1:0]   ldata
);

    localparam int LANES = BUS_W / 8;

    logic [5:0]       bit_shift;
    logic [LANES-1:0] base_mask;
    logic [BUS_W-1:0] shifted;

    assign bit_shift = {offset, 3'b000};

    // Bytes pushed past the top lane fall off; no wrap-around.
    assign wmask = base_mask << offset;
    assign wdata = sdata << bit_shift;
    assign shifted = rdata >> bit_shift;

    always_comb begin
        base_mask = '0;
        case ({1'b0, funct3[1:0]})
            F3_SB:   base_mask = LANES'(8'h01);
            F3_SH:   base_mask = LANES'(8'h03);
            F3_SW:   base_mask = LANES'(8'h0F);
            F3_SD:   base_mask = LANES'(8'hFF);
            default: base_mask = LANES'(8'hFF);
        endcase
    end

    always_comb begin
        ldata = shifted;
        case (funct3)
            F3_LB:   ldata = {{(BUS_W-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   ldata = {{(BUS_W-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   ldata = {{(BUS_W-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   ldata = shifted;
            F3_LBU:  ldata = {{(BUS_W-8){1'b0}},  shifted[7:0]};
            F3_LHU:  ldata = {{(BUS_W-16){1'b0}}, shifted[15:0]};
            F3_LWU:  ldata = {{(BUS_W-32){1'b0}}, shifted[31:0]};
            default: ldata = shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access : MEM-stage load/store unit; optional misalignment trap via
// MEM_MISALIGN_TRAP_EN.                                       Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_W = 64
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               load_i,
    input  logic               store_i,
    input  logic [2:0]         funct3_i,
    input  logic [63:0]        aluout_i,
    input  logic [BUS_W-1:0]   sdata_i,
    input  logic               wen_i,
    input  logic [4:0]         rd_i,
    input  logic               csr_wen_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [63:0]        csr_wdata_i,
    input  logic               exception_i,
    input  logic [63:0]        mcause_i,
    input  logic [63:0]        pc_i,

    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic [63:0]        req_addr_o,
    output logic               req_wen_o,
    output logic [BUS_W-1:0]   req_wdata_o,
    output logic [BUS_W/8-1:0] req_wmask_o,
    input  logic               resp_valid_i,
    input  logic [BUS_W-1:0]   resp_rdata_i,

    output logic               wen_o,
    output logic [4:0]         rd_o,
    output logic [63:0]        wdata_o,
    output logic               csr_wen_o,
    output logic [11:0]        csr_addr_o,
    output logic [63:0]        csr_wdata_o,
    output logic               exception_o,
    output logic [63:0]        mcause_o,
    output logic [63:0]        pc_o,
    output logic               stall_o
);

    state_t           state;
    logic [BUS_W-1:0] rdata_q;
    logic [BUS_W-1:0] load_data;
    logic             mem_op;
    logic             misaligned;

    // An instruction already carrying an exception never touches memory.
    assign mem_op = (load_i | store_i) & ~exception_i;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(funct3_i, aluout_i[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_addr_o = {aluout_i[63:3], 3'b000};
    assign req_wen_o  = store_i;

    mem_align #(
        .BUS_W (BUS_W)
    ) u_align (
        .funct3 (funct3_i),
        .offset (aluout_i[2:0]),
        .sdata  (sdata_i),
        .rdata  (rdata_q),
        .wmask  (req_wmask_o),
        .wdata  (req_wdata_o),
        .ldata  (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op && !misaligned) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A response arriving with the handshake skips WAIT.
                    if (req_ready_i) begin
                        if (resp_valid_i) begin
                            rdata_q <= resp_rdata_i;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (resp_valid_i) begin
                        rdata_q <= resp_rdata_i;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wen_o       = wen_i;
        rd_o        = rd_i;
        wdata_o     = aluout_i;
        csr_wen_o   = csr_wen_i;
        csr_addr_o  = csr_addr_i;
        csr_wdata_o = csr_wdata_i;
        exception_o = exception_i;
        mcause_o    = mcause_i;
        pc_o        = pc_i;
        stall_o     = 1'b0;
        req_valid_o = 1'b0;

        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            exception_o = 1'b1;
                            mcause_o    = load_i ? MCAUSE_LOAD_MISALIGN
                                                 : MCAUSE_STORE_MISALIGN;
                            wen_o       = 1'b0;
                            csr_wen_o   = 1'b0;
                        end else begin
                            stall_o     = 1'b1;
                            wen_o       = 1'b0;
                            csr_wen_o   = 1'b0;
                            exception_o = 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    req_valid_o = 1'b1;
                    stall_o     = 1'b1;
                    wen_o       = 1'b0;
                    csr_wen_o   = 1'b0;
                    exception_o = 1'b0;
                end
                ST_WAIT: begin
                    stall_o     = 1'b1;
                    wen_o       = 1'b0;
                    csr_wen_o   = 1'b0;
                    exception_o = 1'b0;
                end
                ST_DONE: begin
                    if (load_i) begin
                        wdata_o = load_data[63:0];
                    end
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access : directed self-checking bench for mem_access.
//                                                             Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] aluout_i, sdata_i;
    logic        wen_i;
    logic [4:0]  rd_i;
    logic        csr_wen_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic        exception_i;
    logic [63:0] mcause_i, pc_i;
    logic        req_valid_o, req_ready_i;
    logic [63:0] req_addr_o;
    logic        req_wen_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wmask_o;
    logic        resp_valid_i;
    logic [63:0] resp_rdata_i;
    logic        wen_o;
    logic [4:0]  rd_o;
    logic [63:0] wdata_o;
    logic        csr_wen_o;
    logic [11:0] csr_addr_o;
    logic [63:0] csr_wdata_o;
    logic        exception_o;
    logic [63:0] mcause_o, pc_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_access #(.BUS_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_i       (load_i),
        .store_i      (store_i),
        .funct3_i     (funct3_i),
        .aluout_i     (aluout_i),
        .sdata_i      (sdata_i),
        .wen_i        (wen_i),
        .rd_i         (rd_i),
        .csr_wen_i    (csr_wen_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .exception_i  (exception_i),
        .mcause_i     (mcause_i),
        .pc_i         (pc_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_addr_o   (req_addr_o),
        .req_wen_o    (req_wen_o),
        .req_wdata_o  (req_wdata_o),
        .req_wmask_o  (req_wmask_o),
        .resp_valid_i (resp_valid_i),
        .resp_rdata_i (resp_rdata_i),
        .wen_o        (wen_o),
        .rd_o         (rd_o),
        .wdata_o      (wdata_o),
        .csr_wen_o    (csr_wen_o),
        .csr_addr_o   (csr_addr_o),
        .csr_wdata_o  (csr_wdata_o),
        .exception_o  (exception_o),
        .mcause_o     (mcause_o),
        .pc_o         (pc_o),
        .stall_o      (stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        load_i       = 1'b0;
        store_i      = 1'b0;
        funct3_i     = 3'b000;
        aluout_i     = 64'h0;
        sdata_i      = 64'h0;
        wen_i        = 1'b0;
        rd_i         = 5'd0;
        csr_wen_i    = 1'b0;
        csr_addr_i   = 12'h0;
        csr_wdata_i  = 64'h0;
        exception_i  = 1'b0;
        mcause_i     = 64'h0;
        pc_i         = 64'h0;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'h0;
    endtask

    initial begin
        idle_inputs();
        reset    = 1'b1;
        load_i   = 1'b1;
        aluout_i = 64'h55;
        settle();
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_req_valid", 64'(req_valid_o), 64'd0);
        chk("rst_wdata", wdata_o, 64'h55);
        tick();
        reset = 1'b0;
        idle_inputs();

        // ALU pass-through
        aluout_i = 64'h1234;
        wen_i    = 1'b1;
        rd_i     = 5'd5;
        settle();
        chk("alu_wen", 64'(wen_o), 64'd1);
        chk("alu_rd", 64'(rd_o), 64'd5);
        chk("alu_wdata", wdata_o, 64'h1234);
        chk("alu_stall", 64'(stall_o), 64'd0);
        chk("alu_req_valid", 64'(req_valid_o), 64'd0);
        tick();
        idle_inputs();

        // LB with delayed ready and a separate response cycle
        load_i   = 1'b1;
        funct3_i = 3'b000;
        aluout_i = 64'h8000_0003;
        wen_i    = 1'b1;
        rd_i     = 5'd7;
        settle();
        chk("lb_idle_stall", 64'(stall_o), 64'd1);
        chk("lb_idle_wen", 64'(wen_o), 64'd0);
        chk("lb_idle_req_valid", 64'(req_valid_o), 64'd0);
        tick();
        settle();
        chk("lb_req_valid", 64'(req_valid_o), 64'd1);
        chk("lb_req_addr", req_addr_o, 64'h8000_0000);
        chk("lb_req_wen", 64'(req_wen_o), 64'd0);
        chk("lb_req_stall", 64'(stall_o), 64'd1);
        tick();
        req_ready_i = 1'b1;
        settle();
        chk("lb_req_hold", 64'(req_valid_o), 64'd1);
        tick();
        req_ready_i = 1'b0;
        settle();
        chk("lb_wait_req_valid", 64'(req_valid_o), 64'd0);
        chk("lb_wait_stall", 64'(stall_o), 64'd1);
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'h0000_0000_8000_0000;
        tick();
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'h0;
        settle();
        chk("lb_done_stall", 64'(stall_o), 64'd0);
        chk("lb_done_wen", 64'(wen_o), 64'd1);
        chk("lb_done_rd", 64'(rd_o), 64'd7);
        chk("lb_done_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        idle_inputs();
        settle();
        chk("lb_after_stall", 64'(stall_o), 64'd0);
        chk("lb_after_req_valid", 64'(req_valid_o), 64'd0);

        // LHU with ready and response together
        load_i   = 1'b1;
        funct3_i = 3'b101;
        aluout_i = 64'h0000_0000_1000_0006;
        wen_i    = 1'b1;
        rd_i     = 5'd9;
        tick();
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'hBEEF_0000_0000_0000;
        settle();
        chk("lhu_req_valid", 64'(req_valid_o), 64'd1);
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'h0;
        settle();
        chk("lhu_done_wdata", wdata_o, 64'h0000_0000_0000_BEEF);
        chk("lhu_done_wen", 64'(wen_o), 64'd1);
        chk("lhu_done_stall", 64'(stall_o), 64'd0);
        tick();
        idle_inputs();

        // SW at offset 4, ready and ack in the same cycle
        store_i  = 1'b1;
        funct3_i = 3'b010;
        aluout_i = 64'h0000_0000_1000_0004;
        sdata_i  = 64'h0000_0000_DEAD_BEEF;
        settle();
        chk("sw_wmask", 64'(req_wmask_o), 64'hF0);
        chk("sw_wdata", req_wdata_o, 64'hDEAD_BEEF_0000_0000);
        chk("sw_req_wen", 64'(req_wen_o), 64'd1);
        chk("sw_idle_stall", 64'(stall_o), 64'd1);
        tick();
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b1;
        settle();
        chk("sw_req_valid", 64'(req_valid_o), 64'd1);
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        settle();
        chk("sw_done_stall", 64'(stall_o), 64'd0);
        chk("sw_done_wen", 64'(wen_o), 64'd0);
        chk("sw_done_req_valid", 64'(req_valid_o), 64'd0);
        tick();
        idle_inputs();

        // LW sign extension from the upper word
        load_i   = 1'b1;
        funct3_i = 3'b010;
        aluout_i = 64'h0000_0000_1000_0004;
        wen_i    = 1'b1;
        rd_i     = 5'd3;
        tick();
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'h8765_4321_0000_0000;
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        settle();
        chk("lw_done_wdata", wdata_o, 64'hFFFF_FFFF_8765_4321);
        tick();
        idle_inputs();

        // Lane alignment at the edges of the doubleword
        funct3_i = 3'b000;
        aluout_i = 64'h0000_0000_0000_0007;
        sdata_i  = 64'h0000_0000_0000_00AB;
        settle();
        chk("sb7_wmask", 64'(req_wmask_o), 64'h80);
        chk("sb7_wdata", req_wdata_o, 64'hAB00_0000_0000_0000);
        funct3_i = 3'b001;
        aluout_i = 64'h0000_0000_0000_0002;
        sdata_i  = 64'h0000_0000_0000_1234;
        settle();
        chk("sh2_wmask", 64'(req_wmask_o), 64'h0C);
        chk("sh2_wdata", req_wdata_o, 64'h0000_0000_1234_0000);
        idle_inputs();

        // Load carrying an exception passes straight through
        load_i      = 1'b1;
        exception_i = 1'b1;
        mcause_i    = 64'h2;
        pc_i        = 64'h100;
        settle();
        chk("exc_stall", 64'(stall_o), 64'd0);
        chk("exc_exception", 64'(exception_o), 64'd1);
        chk("exc_mcause", mcause_o, 64'h2);
        chk("exc_pc", pc_o, 64'h100);
        tick();
        settle();
        chk("exc_no_req", 64'(req_valid_o), 64'd0);
        idle_inputs();

        // Reset while waiting, then a stray response
        load_i   = 1'b1;
        funct3_i = 3'b011;
        aluout_i = 64'h0000_0000_2000_0000;
        wen_i    = 1'b1;
        rd_i     = 5'd4;
        tick();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        settle();
        chk("rstw_wait_stall", 64'(stall_o), 64'd1);
        chk("rstw_wait_req_valid", 64'(req_valid_o), 64'd0);
        reset = 1'b1;
        #1;
        chk("rstw_rst_stall", 64'(stall_o), 64'd0);
        tick();
        reset        = 1'b0;
        load_i       = 1'b0;
        wen_i        = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
        settle();
        chk("rstw_idle_stall", 64'(stall_o), 64'd0);
        chk("rstw_idle_req_valid", 64'(req_valid_o), 64'd0);
        chk("rstw_idle_wen", 64'(wen_o), 64'd0);
        tick();
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'h0;
        load_i       = 1'b1;
        wen_i        = 1'b1;
        settle();
        chk("rstw_new_op_stall", 64'(stall_o), 64'd1);
        chk("rstw_new_op_req_valid", 64'(req_valid_o), 64'd0);
        tick();
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b1;
        resp_rdata_i = 64'h0123_4567_89AB_CDEF;
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 64'h0;
        settle();
        chk("rstw_ld_wdata", wdata_o, 64'h0123_4567_89AB_CDEF);
        chk("rstw_ld_wen", 64'(wen_o), 64'd1);
        tick();
        idle_inputs();

`ifdef MEM_MISALIGN_TRAP_EN
        load_i   = 1'b1;
        funct3_i = 3'b010;
        aluout_i = 64'h0000_0000_1000_0002;
        wen_i    = 1'b1;
        settle();
        chk("mis_lw_exception", 64'(exception_o), 64'd1);
        chk("mis_lw_mcause", mcause_o, 64'd4);
        chk("mis_lw_req_valid", 64'(req_valid_o), 64'd0);
        chk("mis_lw_stall", 64'(stall_o), 64'd0);
        chk("mis_lw_wen", 64'(wen_o), 64'd0);
        tick();
        settle();
        chk("mis_lw_no_req", 64'(req_valid_o), 64'd0);
        load_i   = 1'b0;
        store_i  = 1'b1;
        funct3_i = 3'b011;
        aluout_i = 64'h0000_0000_1000_0001;
        settle();
        chk("mis_sd_exception", 64'(exception_o), 64'd1);
        chk("mis_sd_mcause", mcause_o, 64'd6);
        chk("mis_sd_stall", 64'(stall_o), 64'd0);
        idle_inputs();
`else
        funct3_i = 3'b010;
        aluout_i = 64'h0000_0000_0000_0006;
        sdata_i  = 64'h0000_0000_1122_3344;
        settle();
        chk("trunc_sw6_wmask", 64'(req_wmask_o), 64'hC0);
        chk("trunc_sw6_wdata", req_wdata_o, 64'h3344_0000_0000_0000);
        idle_inputs();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage load/store unit of the rv64IM pipeline.
- Consumes the ex_mem register outputs and drives the mem_wb register inputs.
- Runs each load/store over a valid/ready request, valid-only response data bus, doing byte-lane alignment, write masking and load extension.
- Raises stall_o so upstream registers hold while an access is outstanding.

Parameters:
- BUS_W, 64, data bus width in bits; only 64 supported, lanes = BUS_W/8.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- load_i  in  1  load in MEM
- store_i  in  1  store in MEM
- funct3_i  in  3  access size/sign (RV64 load/store funct3)
- aluout_i  in  64  address for load/store; result for other ops
- sdata_i  in  64  store data (low bytes used)
- wen_i, rd_i[4:0]  in  regfile write enable/dest
- csr_wen_i, csr_addr_i[11:0], csr_wdata_i[63:0]  in  CSR write pass-through
- exception_i, mcause_i[63:0], pc_i[63:0]  in  exception pass-through
- req_valid_o  out  1  bus request valid
- req_ready_i  in  1  bus accepts request
- req_addr_o  out  64  {aluout_i[63:3],3'b000}
- req_wen_o  out  1  1 = store
- req_wdata_o  out  64  sdata_i << (8*aluout_i[2:0])
- req_wmask_o  out  8  byte-enable
- resp_valid_i  in  1  response/ack valid (one cycle)
- resp_rdata_i  in  64  read data
- wen_o, rd_o, wdata_o[63:0], csr_wen_o, csr_addr_o, csr_wdata_o, exception_o, mcause_o, pc_o  out  to mem_wb
- stall_o  out  1  hold IF/ID/EX/ex_mem

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset forces IDLE and clears rdata_q to 0.
- With reset asserted: req_valid_o=0, stall_o=0, and outputs follow inputs (IDLE path).
- IDLE, no memory op (load_i|store_i=0, or exception_i=1):
  - Outputs equal inputs combinationally; wdata_o=aluout_i; stall_o=0; req_valid_o=0.
  - Latency is 0 cycles beyond the ex_mem register.
- IDLE, memory op:
  - Go to REQ the next cycle.
  - stall_o=1 combinationally in this cycle.
  - Outputs to mem_wb are a bubble: wen_o, csr_wen_o, exception_o = 0.
- REQ:
  - req_valid_o=1; address, data and mask stable.
  - On req_ready_i go to WAIT. The same-cycle resp_valid_i is also accepted: capture rdata, go to DONE.
  - stall_o=1; bubble outputs.
- WAIT:
  - req_valid_o=0.
  - On resp_valid_i capture resp_rdata_i into rdata_q and go to DONE.
  - stall_o=1; bubble outputs.
- DONE:
  - stall_o=0; outputs equal inputs.
  - wdata_o = load ? extend(rdata_q >> 8*aluout_i[2:0]) : aluout_i.
  - Next state IDLE, which prevents re-issue of the held instruction.
- Load extension by funct3:
  - 000 sign-extend byte; 001 sign-extend half; 010 sign-extend word; 011 full 64 bits.
  - 100, 101, 110 zero-extend byte, half, word; 111 treated as 011.
- Store mask: 000 8'h01, 001 8'h03, 010 8'h0F, 011 8'hFF, each << aluout_i[2:0], truncated to 8 bits. Codes 1xx behave as 0xx.
- Stores also wait for resp_valid_i (write ack); wdata_o is don't-care with wen_o=0.
- resp_valid_i outside REQ/WAIT is ignored.
- Reset mid-access returns to IDLE immediately. A later stray response is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined, misaligned access: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0.
  - No bus request; handled in IDLE with 0 latency; stall_o=0.
  - exception_o=1, wen_o=0, csr_wen_o=0.
  - mcause_o=4 for a load, 6 for a store.
- Undefined: no check; lanes beyond byte 7 are dropped by mask/shift truncation.

Decomposition:
- define.v holds:
  - funct3 codes LB..LWU and SB..SD;
  - FSM state encodings (2-bit);
  - MCAUSE_LOAD_MISALIGN=4 and MCAUSE_STORE_MISALIGN=6.
- One combinational sub-module, mem_align, computes wmask, shifted wdata and load extension. The FSM stays in mem_access.

Test Plan:
- ALU op, aluout_i=64'h1234, wen_i=1, rd_i=5 -> same cycle wen_o=1, rd_o=5, wdata_o=64'h1234, stall_o=0, req_valid_o=0.
- LB addr 64'h8000_0003, ready after 2 cycles, resp rdata 64'h0000_0000_8000_0000 one cycle later:
  - stall_o=1 through REQ/WAIT; req_addr_o=64'h8000_0000;
  - DONE wdata_o=64'hFFFF_FFFF_FFFF_FF80 with wen_o=1; IDLE after.
- LHU addr 0x...6 with rdata 64'hBEEF_0000_0000_0000 -> wdata_o=64'h0000_0000_0000_BEEF.
- SW addr 0x...4, sdata 64'hDEADBEEF, ready and ack in same cycle:
  - req_wmask_o=8'hF0, req_wdata_o=64'hDEADBEEF_0000_0000, req_wen_o=1;
  - DONE the next cycle, wen_o=0.
- Reset asserted in WAIT, then resp_valid_i pulse -> FSM IDLE, stall_o=0, response ignored, no write.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x...2:
  - exception_o=1, mcause_o=4, req_valid_o=0, stall_o=0.
  - The same access with SD at addr 0x...1 gives mcause_o=6.
